// File: rtl/step_seq_pkg.sv
// Shared types and default widths for the step/dir motion sequencer.
package step_seq_pkg;

  localparam int unsigned CmdDepthDef = 4;
  localparam int unsigned StepsW      = 16;
  localparam int unsigned PeriodW     = 16;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StDirSetup,
    StPulseHigh,
    StPulseLow
  } state_e;

  typedef struct packed {
    logic               dir;
    logic [StepsW-1:0]  steps;
    logic [PeriodW-1:0] period;
  } cmd_t;

  // A zero-length timing phase is meaningless on the pins, so zero means one cycle.
  function automatic logic [7:0] at_least_one(logic [7:0] v);
    return (v == 8'd0) ? 8'd1 : v;
  endfunction

endpackage

// File: rtl/step_cmd_fifo.sv
// Synchronous command FIFO with occupancy counter and a flush that empties it in one cycle.
module step_cmd_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CntW'(1);
      else if (!do_push && do_pop) count_q <= count_q - CntW'(1);
    end
  end

endmodule

// File: rtl/step_sequencer.sv
// Single-axis step/dir sequencer: queues move commands and emits timed step pulses.
module step_sequencer
  import step_seq_pkg::*;
#(
  parameter int unsigned CMD_DEPTH = CmdDepthDef,
  parameter int unsigned STEPS_W   = StepsW,
  parameter int unsigned PERIOD_W  = PeriodW
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_dir,
  input  logic [STEPS_W-1:0]  cmd_steps,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic [7:0]          cfg_pulse_width,
  input  logic [7:0]          cfg_dir_setup,
  input  logic                cfg_invert_dir,
  input  logic                halt,
  output logic                step,
  output logic                dir,
  output logic                busy,
  output logic                done,
  output logic [31:0]         position
);

  state_e              state_q;
  cmd_t                cmd_q, fifo_rdata, fifo_wdata;
  logic                fifo_full, fifo_empty, fifo_push, fifo_pop, last_low;
  logic [PERIOD_W-1:0] timer_q, low_len, pw_eff, ds_eff;
  logic [STEPS_W-1:0]  remaining_q;
  logic [7:0]          h_q;
  logic [31:0]         position_q, pos_next;
  logic                dir_log_q, dir_q, step_q, done_q, halt_pend_q;

  assign cmd_ready  = !fifo_full && !halt && resetn;
  assign fifo_push  = cmd_valid && cmd_ready;
  assign fifo_wdata = '{dir: cmd_dir, steps: cmd_steps, period: cmd_period};
  assign last_low   = (state_q == StPulseLow) && (timer_q <= PERIOD_W'(1)) &&
                      (remaining_q == '0);
  // Popping in the final low cycle lets the next command load with no idle gap.
  assign fifo_pop   = !halt && !fifo_empty && ((state_q == StIdle) || last_low);

  assign pw_eff   = PERIOD_W'(at_least_one(cfg_pulse_width));
  assign ds_eff   = PERIOD_W'(at_least_one(cfg_dir_setup));
  assign low_len  = (cmd_q.period > PERIOD_W'(h_q)) ? cmd_q.period - PERIOD_W'(h_q)
                                                    : PERIOD_W'(1);
  assign pos_next = dir_log_q ? position_q + 32'd1 : position_q - 32'd1;

  step_cmd_fifo #(
    .Depth(CMD_DEPTH),
    .Width($bits(cmd_t))
  ) u_fifo (
    .clk   (clk),
    .resetn(resetn),
    .flush (halt),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= StIdle;
      cmd_q       <= '0;
      timer_q     <= '0;
      remaining_q <= '0;
      h_q         <= 8'd1;
      position_q  <= '0;
      dir_log_q   <= 1'b0;
      dir_q       <= cfg_invert_dir;
      step_q      <= 1'b0;
      done_q      <= 1'b0;
      halt_pend_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dir_q  <= dir_log_q ^ cfg_invert_dir;
      unique case (state_q)
        StIdle: begin
          halt_pend_q <= 1'b0;
          if (fifo_pop) begin
            cmd_q   <= fifo_rdata;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          if (halt) begin
            state_q <= StIdle;
          end else if (cmd_q.steps == '0) begin
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else if (cmd_q.dir != dir_log_q) begin
            dir_log_q   <= cmd_q.dir;
            dir_q       <= cmd_q.dir ^ cfg_invert_dir;
            remaining_q <= cmd_q.steps;
            timer_q     <= ds_eff;
            state_q     <= StDirSetup;
          end else begin
            state_q     <= StPulseHigh;
            step_q      <= 1'b1;
            timer_q     <= pw_eff;
            h_q         <= at_least_one(cfg_pulse_width);
            position_q  <= pos_next;
            remaining_q <= cmd_q.steps - STEPS_W'(1);
          end
        end
        StDirSetup: begin
          if (halt) begin
            state_q <= StIdle;
          end else if (timer_q <= PERIOD_W'(1)) begin
            state_q     <= StPulseHigh;
            step_q      <= 1'b1;
            timer_q     <= pw_eff;
            h_q         <= at_least_one(cfg_pulse_width);
            position_q  <= pos_next;
            remaining_q <= remaining_q - STEPS_W'(1);
          end else begin
            timer_q <= timer_q - PERIOD_W'(1);
          end
        end
        StPulseHigh: begin
          // A halt here still lets the pulse complete so the driver never sees a runt.
          if (halt) halt_pend_q <= 1'b1;
          if (timer_q <= PERIOD_W'(1)) begin
            step_q <= 1'b0;
            if (halt || halt_pend_q) begin
              state_q <= StIdle;
            end else begin
              timer_q <= low_len;
              state_q <= StPulseLow;
            end
          end else begin
            timer_q <= timer_q - PERIOD_W'(1);
          end
        end
        StPulseLow: begin
          if (halt) begin
            state_q <= StIdle;
          end else if (timer_q <= PERIOD_W'(1)) begin
            if (remaining_q != '0) begin
              state_q     <= StPulseHigh;
              step_q      <= 1'b1;
              timer_q     <= pw_eff;
              h_q         <= at_least_one(cfg_pulse_width);
              position_q  <= pos_next;
              remaining_q <= remaining_q - STEPS_W'(1);
            end else begin
              done_q <= 1'b1;
              if (fifo_pop) begin
                cmd_q   <= fifo_rdata;
                state_q <= StLoad;
              end else begin
                state_q <= StIdle;
              end
            end
          end else begin
            timer_q <= timer_q - PERIOD_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign step     = step_q;
  assign dir      = dir_q;
  assign done     = done_q;
  assign position = position_q;
  assign busy     = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: directed scenarios plus random batches against a timeline model.
module tb_step_sequencer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_dir = 1'b0;
  logic [15:0] cmd_steps = '0;
  logic [15:0] cmd_period = '0;
  logic [7:0]  cfg_pulse_width = 8'd1;
  logic [7:0]  cfg_dir_setup = 8'd1;
  logic        cfg_invert_dir = 1'b0;
  logic        halt = 1'b0;
  logic        cmd_ready, step, dir, busy, done;
  logic [31:0] position;

  always #5 clk = ~clk;

  step_sequencer #(
    .CMD_DEPTH(4),
    .STEPS_W  (16),
    .PERIOD_W (16)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_dir        (cmd_dir),
    .cmd_steps      (cmd_steps),
    .cmd_period     (cmd_period),
    .cfg_pulse_width(cfg_pulse_width),
    .cfg_dir_setup  (cfg_dir_setup),
    .cfg_invert_dir (cfg_invert_dir),
    .halt           (halt),
    .step           (step),
    .dir            (dir),
    .busy           (busy),
    .done           (done),
    .position       (position)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed pin activity, indexed by cycle number.
  int   rise_q[$], dn_q[$], width_q[$];
  int   hcnt = 0;
  logic step_prev = 1'b0;
  always @(negedge clk) begin
    step_prev <= step;
    if (step && !step_prev) begin
      rise_q.push_back(cyc);
      hcnt <= 1;
    end else if (step) begin
      hcnt <= hcnt + 1;
    end
    if (!step && step_prev) width_q.push_back(hcnt);
    if (done) dn_q.push_back(cyc);
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model state: logical direction and commanded position.
  logic        mdir = 1'b0;
  logic [31:0] exp_pos = '0;
  int          exp_rise[$], exp_done[$];
  logic        bdir[5];
  logic [15:0] bsteps[5], bper[5];

  task automatic clear_obs();
    rise_q.delete();
    dn_q.delete();
    width_q.delete();
    exp_rise.delete();
    exp_done.delete();
  endtask

  // Push n commands on consecutive cycles, predict the pin timeline, compare after idle.
  task automatic run_batch(input string tag, input int n, input bit expect_full);
    int h, s, t, r, pp, n0;
    clear_obs();
    h  = (cfg_pulse_width == 0) ? 1 : int'(cfg_pulse_width);
    s  = (cfg_dir_setup == 0) ? 1 : int'(cfg_dir_setup);
    n0 = cyc;
    t  = n0 + 2;
    for (int i = 0; i < n; i++) begin
      if (bsteps[i] == 0) begin
        exp_done.push_back(t + 1);
        t += 2;
      end else begin
        pp = (int'(bper[i]) > h) ? int'(bper[i]) : h + 1;
        r  = t + 1;
        if (bdir[i] != mdir) begin
          r += s;
          mdir = bdir[i];
        end
        for (int k = 0; k < int'(bsteps[i]); k++) begin
          exp_rise.push_back(r + k * pp);
          exp_pos = bdir[i] ? exp_pos + 32'd1 : exp_pos - 32'd1;
        end
        t = r + int'(bsteps[i]) * pp;
        exp_done.push_back(t);
      end
    end
    for (int i = 0; i < n; i++) begin
      cmd_valid  = 1'b1;
      cmd_dir    = bdir[i];
      cmd_steps  = bsteps[i];
      cmd_period = bper[i];
      check({tag, "_ready"}, cmd_ready, 1);
      @(posedge clk) #1;
    end
    cmd_valid = 1'b0;
    if (expect_full) check({tag, "_full"}, cmd_ready, 0);
    for (int k = 0; k < 3000 && busy; k++) @(posedge clk) #1;
    check({tag, "_idle"}, busy, 0);
    repeat (3) @(posedge clk) #1;
    check({tag, "_nrise"}, rise_q.size(), exp_rise.size());
    foreach (exp_rise[i])
      check($sformatf("%s_rise%0d", tag, i), (i < rise_q.size()) ? rise_q[i] : -1, exp_rise[i]);
    foreach (width_q[i]) check($sformatf("%s_width%0d", tag, i), width_q[i], h);
    check({tag, "_ndone"}, dn_q.size(), exp_done.size());
    foreach (exp_done[i])
      check($sformatf("%s_done%0d", tag, i), (i < dn_q.size()) ? dn_q[i] : -1, exp_done[i]);
    check({tag, "_pos"}, position, exp_pos);
    check({tag, "_dir"}, dir, mdir ^ cfg_invert_dir);
  endtask

  task automatic set_cfg(input int pw, input int ds, input bit inv);
    cfg_pulse_width = 8'(pw);
    cfg_dir_setup   = 8'(ds);
    cfg_invert_dir  = inv;
    repeat (2) @(posedge clk) #1;
  endtask

  initial begin
    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", cmd_ready, 0);
    @(negedge clk);
    check("rst_step", step, 0);
    check("rst_dir", dir, 0);
    check("rst_pos", position, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    @(posedge clk) #1;
    resetn = 1'b1;
    @(posedge clk) #1;

    set_cfg(4, 2, 1'b0);
    bdir[0] = 1'b1; bsteps[0] = 16'd3; bper[0] = 16'd10;
    run_batch("single", 1, 1'b0);

    set_cfg(4, 5, 1'b0);
    bdir[0] = 1'b1; bsteps[0] = 16'd2; bper[0] = 16'd8;
    bdir[1] = 1'b0; bsteps[1] = 16'd2; bper[1] = 16'd8;
    run_batch("reverse", 2, 1'b0);

    set_cfg(4, 1, 1'b0);
    bdir[0] = 1'b0; bsteps[0] = 16'd3; bper[0] = 16'd2;
    bdir[1] = 1'b1; bsteps[1] = 16'd0; bper[1] = 16'd7;
    run_batch("clamp", 2, 1'b0);

    set_cfg(2, 1, 1'b0);
    bdir[0] = 1'b1; bsteps[0] = 16'd3; bper[0] = 16'd10;
    bdir[1] = 1'b0; bsteps[1] = 16'd2; bper[1] = 16'd4;
    bdir[2] = 1'b1; bsteps[2] = 16'd1; bper[2] = 16'd3;
    bdir[3] = 1'b1; bsteps[3] = 16'd2; bper[3] = 16'd6;
    bdir[4] = 1'b0; bsteps[4] = 16'd1; bper[4] = 16'd9;
    run_batch("bp", 5, 1'b1);

    for (int b = 0; b < 6; b++) begin
      set_cfg(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
      for (int i = 0; i < 4; i++) begin
        bdir[i]   = 1'($urandom_range(0, 1));
        bsteps[i] = 16'($urandom_range(0, 4));
        bper[i]   = 16'($urandom_range(0, 12));
      end
      run_batch($sformatf("rnd%0d", b), int'($urandom_range(1, 4)), 1'b0);
    end

    // Halt during the second high phase: pulse completes, queue is flushed, no done.
    set_cfg(4, 1, 1'b0);
    clear_obs();
    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd10; cmd_period = 16'd10;
    @(posedge clk) #1;
    cmd_dir = 1'b0; cmd_steps = 16'd3; cmd_period = 16'd5;
    @(posedge clk) #1;
    cmd_valid = 1'b0;
    for (int k = 0; k < 200 && rise_q.size() < 2; k++) @(posedge clk) #1;
    halt = 1'b1;
    #1;
    check("halt_ready", cmd_ready, 0);
    @(posedge clk) #1;
    halt = 1'b0;
    repeat (40) @(posedge clk) #1;
    mdir    = 1'b1;
    exp_pos = exp_pos + 32'd2;
    check("halt_nrise", rise_q.size(), 2);
    check("halt_width", (width_q.size() >= 2) ? width_q[1] : 0, 4);
    check("halt_ndone", dn_q.size(), 0);
    check("halt_busy", busy, 0);
    check("halt_pos", position, exp_pos);

    // Reset in the middle of a pulse with an inverted dir pin.
    set_cfg(4, 1, 1'b1);
    clear_obs();
    cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_steps = 16'd10; cmd_period = 16'd10;
    @(posedge clk) #1;
    cmd_valid = 1'b0;
    for (int k = 0; k < 200 && rise_q.size() < 1; k++) @(posedge clk) #1;
    check("mid_step", step, 1);
    resetn = 1'b0;
    #1;
    check("mid_ready", cmd_ready, 0);
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_step", step, 0);
    check("mid_rst_pos", position, 0);
    check("mid_rst_dir", dir, 1);
    check("mid_rst_busy", busy, 0);
    @(posedge clk) #1;
    resetn  = 1'b1;
    mdir    = 1'b0;
    exp_pos = '0;
    @(posedge clk) #1;

    set_cfg(3, 2, 1'b1);
    bdir[0] = 1'b0; bsteps[0] = 16'd2; bper[0] = 16'd6;
    bdir[1] = 1'b1; bsteps[1] = 16'd3; bper[1] = 16'd4;
    run_batch("post_rst", 2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/step_sequencer.md
# step_sequencer

Motion-command sequencer that drives a stepper driver's step/dir pins from a small queue of move commands. Each command gives a direction, a step count and a step period. The block enforces the direction-setup time and the minimum step pulse width, and tracks the commanded position. It sits upstream of the driver and of the position counter that observes step/dir, and is the single owner of the step/dir pins for one axis.

## Interface
- CMD_DEPTH, 4, command FIFO entries (power of 2, ≥2)
- STEPS_W, 16, width of step count per command
- PERIOD_W, 16, width of step period in clk cycles
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept a command
- cmd_dir  in  1  logical direction (1 = positive)
- cmd_steps  in  STEPS_W  steps to emit
- cmd_period  in  PERIOD_W  cycles from one step rising edge to the next
- cfg_pulse_width  in  8  step high time in cycles (0 treated as 1)
- cfg_dir_setup  in  8  cycles between dir change and next step rise (0 treated as 1)
- cfg_invert_dir  in  1  inverts the dir pin only
- halt  in  1  abort current move and flush queue
- step  out  1  step pin, registered
- dir  out  1  dir pin, registered, equals logical dir ^ cfg_invert_dir
- busy  out  1  FSM not IDLE or FIFO non-empty
- done  out  1  one-cycle pulse on normal completion of each command
- position  out  32  commanded position, two's complement

## Operation
- A command is accepted when cmd_valid && cmd_ready. cmd_ready = !full && !halt && resetn.
- FSM states: IDLE, LOAD, DIR_SETUP, PULSE_HIGH, PULSE_LOW.
- IDLE: if the FIFO is non-empty, pop and go to LOAD.
- LOAD:
  - cmd_steps == 0: pulse done, return to IDLE, pins unchanged.
  - Logical dir differs from the current logical dir: update dir and go to DIR_SETUP.
  - Otherwise go to PULSE_HIGH.
- DIR_SETUP: hold for max(cfg_dir_setup, 1) cycles, then go to PULSE_HIGH.
- PULSE_HIGH:
  - step = 1 for H = max(cfg_pulse_width, 1) cycles.
  - On entry, position += 1 if logical dir = 1, else −= 1. Position wraps mod 2^32.
- PULSE_LOW:
  - step = 0 for max(cmd_period − H, 1) cycles.
  - Periods ≤ H are therefore clamped to H+1.
  - If steps remain, go to PULSE_HIGH. Otherwise pulse done.
  - After the last step: if the FIFO is non-empty, pop and go directly to LOAD (back-to-back commands, no idle gap). Otherwise go to IDLE.
- cfg_* inputs are sampled at each phase start. Changing them mid-phase does not affect the running phase.
- halt:
  - In PULSE_HIGH: finish the high phase (no runt pulse), then go to IDLE.
  - In any other state: go to IDLE next cycle.
  - The FIFO is flushed in the same cycle halt is seen.
  - done is not pulsed for an aborted command. position keeps the count of the steps actually emitted.
- The logical dir register persists across commands and halt, and resets to 0.

## Timing
- Reset values: step=0, dir=cfg_invert_dir (logical 0), position=0, done=0, busy=0, FIFO empty, state IDLE.
- cmd_ready is 0 while resetn=0.
- Reset mid-pulse drops step in the next cycle; no completion of the pulse.
- Latency, same dir, idle and empty: command accepted in cycle N, pop in N+1, LOAD in N+2, step high in N+3.
- Latency with a dir change: dir toggles at N+3, step rises at N+3+max(cfg_dir_setup,1).
- Rising-edge spacing within a command is exactly max(cmd_period, H+1) cycles.
- Between commands, the last falling phase is followed by LOAD (1 cycle), so spacing is period+1 without a dir change.
- FIFO full: cmd_ready=0. A push is allowed in the same cycle as a pop only when not full before the pop (no fall-through).
- done is asserted in the cycle after the final PULSE_LOW cycle, or the cycle after LOAD for steps=0.

## Structure
- Package step_seq_pkg holds:
  - the state enum;
  - the command struct {dir, steps, period};
  - default widths.
- One sub-module, step_cmd_fifo: synchronous FIFO parameterised by depth and width, with a flush input. Occupancy is tracked by a counter.
- The sequencer FSM, phase timer (PERIOD_W bits), remaining-steps counter and position register live in the top module.

## Test plan
- Single move: dir=1, steps=3, period=10, pulse=4, setup=2 → three 4-cycle highs with rises 10 cycles apart, position 0→3, one done, busy low afterwards.
- Direction reversal: (1,2,8) then (0,2,8), setup=5 → dir toggles, first reverse rise 5 cycles later, position 0→2→0, two dones.
- Clamp and zero: period=2, pulse=4 → rises every 5 cycles. Steps=0 command → done pulse only, no step, no dir change.
- Backpressure: push 5 commands into CMD_DEPTH=4 while busy → cmd_ready=0 after 4 are queued, all 5 executed in order, with matching position total.
- Halt mid-pulse: assert halt during the 2nd high of steps=10 → pulse finishes full width, no further steps, FIFO empty, position=2, no done.
- Reset mid-move with invert_dir=1: step=0, position=0, dir=1 the cycle after reset.
